// File: rtl/mult_seq_control.sv
// Sequential shift-add unsigned multiplier controller for the MULT path.
// Owns the operand/product registers and the step counter; start/busy/done handshake.

module mult_seq_control #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t               state_q,   state_d;
   logic [WIDTH-1:0]     mcand_q,   mcand_d;
   logic [2*WIDTH-1:0]   preg_q,    preg_d;
   logic [CNT_W-1:0]     cnt_q,     cnt_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
   logic                 busy_q,    busy_d;
   logic                 done_q,    done_d;

   logic                 add_en_s;
   logic [WIDTH:0]       sum_s;
   logic [2*WIDTH-1:0]   step_s;

   // Shift-add step datapath: one conditional add of the multiplicand per cycle.
   always_comb begin
      add_en_s = preg_q[0];
      if (add_en_s) begin
         sum_s = {1'b0, preg_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
      end else begin
         sum_s = {1'b0, preg_q[2*WIDTH-1:WIDTH]};
      end
      // The carry-out of the add becomes the new MSB, so nothing is lost.
      step_s = {sum_s, preg_q[WIDTH-1:1]};
   end

   // Next-state and next-register logic for the IDLE -> RUN -> DONE sequence.
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      preg_d    = preg_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mcand_d = multiplicand;
               preg_d  = {{WIDTH{1'b0}}, multiplier};
               cnt_d   = {CNT_W{1'b0}};
               state_d = ST_RUN;
               busy_d  = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            preg_d = step_s;
            cnt_d  = cnt_q + CNT_ONE;
            if (cnt_q == LAST_CNT) begin
               product_d = step_s;
               state_d   = ST_DONE;
               done_d    = 1'b1;
            end else begin
               busy_d = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         mcand_q   <= {WIDTH{1'b0}};
         preg_q    <= {(2*WIDTH){1'b0}};
         cnt_q     <= {CNT_W{1'b0}};
         product_q <= {(2*WIDTH){1'b0}};
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         preg_q    <= preg_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_mult_seq_control.sv
// Directed self-checking bench for mult_seq_control (WIDTH=16).
// Inputs are driven and outputs sampled on the falling edge; sample n follows rising edge k+n.

module tb_mult_seq_control;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] multiplicand;
   logic [15:0] multiplier;
   logic        busy;
   logic        done;
   logic [31:0] product;

   int total;
   int bad;

   mult_seq_control #(.WIDTH(16), .CNT_W(5)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one start; returns at sample 0 (just after the accepting edge k).
   task automatic accept(input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      start        = 1'b1;
      multiplicand = a;
      multiplier   = b;
      @(negedge clk);
      start        = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      multiplicand = 16'h0000;
      multiplier   = 16'h0000;
      repeat (3) @(negedge clk);
      total++;
      if ({busy, done, product} !== {1'b0, 1'b0, 32'h0000_0000}) begin
         bad++;
         $display("FAIL reset: busy=%0b done=%0b product=%h, want 0 0 00000000", busy, done, product);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      accept(16'd3, 16'd5);
      for (int n = 0; n < 16; n++) begin
         if (n > 0) @(negedge clk);
         total++;
         if (busy !== 1'b1 || done !== 1'b0 || product !== 32'h0000_0000) begin
            bad++;
            $display("FAIL basic_run n=%0d: busy=%0b done=%0b product=%h, want 1 0 00000000", n, busy, done, product);
         end
      end
      @(negedge clk);
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || product !== 32'h0000_000F) begin
         bad++;
         $display("FAIL basic_done: done=%0b busy=%0b product=%h, want 1 0 0000000f", done, busy, product);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || product !== 32'h0000_000F) begin
         bad++;
         $display("FAIL basic_pulse: done=%0b product=%h, want 0 0000000f", done, product);
      end
   endtask

   task automatic test_values();
      logic [15:0] va [4] = '{16'hFFFF, 16'h0000, 16'h1234, 16'h8000};
      logic [15:0] vb [4] = '{16'hFFFF, 16'h1234, 16'h0000, 16'h0002};
      logic [31:0] ve [4] = '{32'hFFFE_0001, 32'h0000_0000, 32'h0000_0000, 32'h0001_0000};
      logic [31:0] prev;
      prev = 32'h0000_000F;
      for (int v = 0; v < 4; v++) begin
         accept(va[v], vb[v]);
         repeat (15) @(negedge clk);
         total++;
         if (busy !== 1'b1 || product !== prev) begin
            bad++;
            $display("FAIL values_hold v=%0d: busy=%0b product=%h, want 1 %h", v, busy, product, prev);
         end
         @(negedge clk);
         total++;
         if (done !== 1'b1 || product !== ve[v]) begin
            bad++;
            $display("FAIL values_result v=%0d: done=%0b product=%h, want 1 %h", v, done, product, ve[v]);
         end
         prev = ve[v];
         @(negedge clk);
      end
   endtask

   task automatic test_ignore_start();
      int dones;
      int done_at;
      dones   = 0;
      done_at = -1;
      accept(16'd6, 16'd9);
      for (int n = 0; n < 22; n++) begin
         if (n > 0) @(negedge clk);
         if (done === 1'b1) begin
            dones++;
            done_at = n;
            total++;
            if (product !== 32'h0000_0036) begin
               bad++;
               $display("FAIL ignore_result: product=%h, want 00000036", product);
            end
         end
         if (n == 4) begin
            start        = 1'b1;
            multiplicand = 16'd7;
            multiplier   = 16'd7;
         end
         if (n == 7) start = 1'b0;
      end
      total++;
      if (dones !== 1 || done_at !== 16) begin
         bad++;
         $display("FAIL ignore_pulse: dones=%0d at=%0d, want 1 at 16", dones, done_at);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL ignore_idle: busy=%0b, want 0", busy);
      end
   endtask

   task automatic test_reset_mid_run();
      int dones;
      dones = 0;
      accept(16'hABCD, 16'h1234);
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      total++;
      if ({busy, done, product} !== {1'b0, 1'b0, 32'h0000_0000}) begin
         bad++;
         $display("FAIL abort_state: busy=%0b done=%0b product=%h, want 0 0 00000000", busy, done, product);
      end
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) dones++;
      end
      total++;
      if (dones !== 0) begin
         bad++;
         $display("FAIL abort_quiet: active_samples=%0d, want 0", dones);
      end
      accept(16'd2, 16'd3);
      repeat (16) @(negedge clk);
      total++;
      if (done !== 1'b1 || product !== 32'h0000_0006) begin
         bad++;
         $display("FAIL abort_fresh: done=%0b product=%h, want 1 00000006", done, product);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int  second_at;
      logic prev_busy;
      second_at = -1;
      @(negedge clk);
      start        = 1'b1;
      multiplicand = 16'h00BE;
      multiplier   = 16'h0011;
      @(negedge clk);
      prev_busy = busy;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL b2b_first_accept: busy=%0b, want 1", busy);
      end
      for (int n = 1; n <= 36; n++) begin
         @(negedge clk);
         if (n == 16) begin
            total++;
            if (done !== 1'b1 || product !== 32'h0000_0C9E) begin
               bad++;
               $display("FAIL b2b_first_result: done=%0b product=%h, want 1 00000c9e", done, product);
            end
            multiplicand = 16'h1000;
            multiplier   = 16'h1000;
         end
         if (busy === 1'b1 && prev_busy === 1'b0 && second_at < 0) begin
            second_at = n;
            start     = 1'b0;
         end
         if (n == 34) begin
            total++;
            if (done !== 1'b1 || product !== 32'h0100_0000) begin
               bad++;
               $display("FAIL b2b_second_result: done=%0b product=%h, want 1 01000000", done, product);
            end
         end
         prev_busy = busy;
      end
      start = 1'b0;
      total++;
      if (second_at !== 18) begin
         bad++;
         $display("FAIL b2b_gap: edges=%0d, want 18", second_at);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_basic();
      test_values();
      test_ignore_start();
      test_reset_mid_run();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
